// File: rtl/morra_driver.sv
// Morra match sequencer: drives pseudo-random moves from an 8-bit LFSR into a
// Mealy game model, tallies rounds and latches the match outcome.
//   state  | meaning
//   IDLE   | waiting for start, last match results held
//   INIT   | one-cycle inizia pulse, moves blanked
//   PLAY   | moves presented, round result sampled at cycle end
//   CHECK  | moves blanked, decide next round / finish / abort
//   FINISH | one-cycle done pulse
module morra_driver #(
  parameter int         MAX_ROUNDS   = 15,
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [1:0] manche,
  input  logic [1:0] partita,
  output logic [1:0] primo,
  output logic [1:0] secondo,
  output logic       inizia,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic       abort,
  output logic [3:0] wins1,
  output logic [3:0] wins2,
  output logic [3:0] rounds
);

  typedef enum logic [2:0] {IDLE, INIT, PLAY, CHECK, FINISH} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr, w_lfsr_nxt;
  logic [1:0] r_partita, w_partita_nxt;
  logic [1:0] r_primo, r_secondo, w_primo_nxt, w_secondo_nxt;
  logic       r_inizia, r_busy, r_done, r_abort, w_abort_nxt;
  logic [1:0] r_result, w_result_nxt;
  logic [3:0] r_wins1, r_wins2, r_rounds;
  logic [3:0] w_wins1_nxt, w_wins2_nxt, w_rounds_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [1:0] move_map(input logic [1:0] v);
    return (v == 2'b00) ? 2'b01 : v;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_partita_nxt = r_partita;
    w_result_nxt  = r_result;
    w_abort_nxt   = r_abort;
    w_wins1_nxt   = r_wins1;
    w_wins2_nxt   = r_wins2;
    w_rounds_nxt  = r_rounds;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_lfsr_nxt   = (seed == 8'h00) ? DEFAULT_SEED : seed;
          w_wins1_nxt  = 4'd0;
          w_wins2_nxt  = 4'd0;
          w_rounds_nxt = 4'd0;
          w_result_nxt = 2'b00;
          w_abort_nxt  = 1'b0;
          w_state_nxt  = INIT;
        end
      end
      INIT: w_state_nxt = PLAY;
      PLAY: begin
        w_lfsr_nxt    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        w_partita_nxt = partita;
        case (manche)
          2'b01: begin
            w_wins1_nxt  = sat_inc(r_wins1);
            w_rounds_nxt = sat_inc(r_rounds);
          end
          2'b10: begin
            w_wins2_nxt  = sat_inc(r_wins2);
            w_rounds_nxt = sat_inc(r_rounds);
          end
          2'b11:   w_rounds_nxt = sat_inc(r_rounds);
          default: ;
        endcase
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (r_partita != 2'b00) begin
          w_result_nxt = r_partita;
          w_state_nxt  = FINISH;
        end else if (int'(r_rounds) == MAX_ROUNDS) begin
          w_abort_nxt  = 1'b1;
          w_result_nxt = 2'b00;
          w_state_nxt  = FINISH;
        end else begin
          w_state_nxt = PLAY;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Moves are registered, so they are derived from the state/LFSR being entered.
    w_primo_nxt   = 2'b00;
    w_secondo_nxt = 2'b00;
    if (w_state_nxt == PLAY) begin
      w_primo_nxt   = move_map(w_lfsr_nxt[1:0]);
      w_secondo_nxt = move_map(w_lfsr_nxt[3:2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lfsr    <= DEFAULT_SEED;
      r_partita <= 2'b00;
      r_primo   <= 2'b00;
      r_secondo <= 2'b00;
      r_inizia  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 2'b00;
      r_abort   <= 1'b0;
      r_wins1   <= 4'd0;
      r_wins2   <= 4'd0;
      r_rounds  <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_partita <= w_partita_nxt;
      r_primo   <= w_primo_nxt;
      r_secondo <= w_secondo_nxt;
      r_inizia  <= (w_state_nxt == INIT);
      r_busy    <= (w_state_nxt == INIT) || (w_state_nxt == PLAY) || (w_state_nxt == CHECK);
      r_done    <= (w_state_nxt == FINISH);
      r_result  <= w_result_nxt;
      r_abort   <= w_abort_nxt;
      r_wins1   <= w_wins1_nxt;
      r_wins2   <= w_wins2_nxt;
      r_rounds  <= w_rounds_nxt;
    end
  end

  assign primo   = r_primo;
  assign secondo = r_secondo;
  assign inizia  = r_inizia;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign abort   = r_abort;
  assign wins1   = r_wins1;
  assign wins2   = r_wins2;
  assign rounds  = r_rounds;

endmodule

// File: tb/tb_morra_driver.sv
// Bench for morra_driver: three instances (MAX_ROUNDS 15, 2, 20) driven one at a
// time from a match-level model of moves, tallies and outcome.
module tb_morra_driver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic [7:0] seed;
  logic [1:0] manche, partita;

  logic [1:0] primo[3], secondo[3], result[3];
  logic       inizia[3], busy[3], done[3], abort[3];
  logic [3:0] wins1[3], wins2[3], rounds[3];

  int total = 0;
  int bad   = 0;
  logic [1:0] mq[$];
  logic [1:0] pq[$];

  morra_driver u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .seed(seed), .manche(manche), .partita(partita),
    .primo(primo[0]), .secondo(secondo[0]), .inizia(inizia[0]), .busy(busy[0]), .done(done[0]),
    .result(result[0]), .abort(abort[0]), .wins1(wins1[0]), .wins2(wins2[0]), .rounds(rounds[0]));

  morra_driver #(.MAX_ROUNDS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .seed(seed), .manche(manche), .partita(partita),
    .primo(primo[1]), .secondo(secondo[1]), .inizia(inizia[1]), .busy(busy[1]), .done(done[1]),
    .result(result[1]), .abort(abort[1]), .wins1(wins1[1]), .wins2(wins2[1]), .rounds(rounds[1]));

  morra_driver #(.MAX_ROUNDS(20)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .seed(seed), .manche(manche), .partita(partita),
    .primo(primo[2]), .secondo(secondo[2]), .inizia(inizia[2]), .busy(busy[2]), .done(done[2]),
    .result(result[2]), .abort(abort[2]), .wins1(wins1[2]), .wins2(wins2[2]), .rounds(rounds[2]));

  function automatic logic [7:0] lf_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] mv(input logic [1:0] x);
    return (x == 2'b00) ? 2'b01 : x;
  endfunction

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plays one match on instance k using the queued round results.
  task automatic run_match(input int k, input int maxr, input logic [7:0] sd, input bit hold);
    logic [7:0] l;
    int w1, w2, rn;
    logic [1:0] exp_res, m, p;
    bit exp_ab, fin;
    seed = sd;
    start_v[k] = 1'b1;
    tick;
    total++;
    if (inizia[k] !== 1'b1 || busy[k] !== 1'b1 || primo[k] !== 2'b00 || secondo[k] !== 2'b00 ||
        rounds[k] !== 4'd0 || wins1[k] !== 4'd0 || wins2[k] !== 4'd0 || abort[k] !== 1'b0 || result[k] !== 2'b00) begin
      bad++;
      $display("FAIL init k=%0d got inizia=%b busy=%b primo=%b secondo=%b rounds=%0d w1=%0d w2=%0d abort=%b result=%b expected 1 1 00 00 0 0 0 0 00",
               k, inizia[k], busy[k], primo[k], secondo[k], rounds[k], wins1[k], wins2[k], abort[k], result[k]);
    end
    if (!hold) start_v[k] = 1'b0;
    l = (sd == 8'h00) ? 8'hA5 : sd;
    w1 = 0; w2 = 0; rn = 0; fin = 0; exp_res = 2'b00; exp_ab = 0;
    while (!fin) begin
      tick;
      total++;
      if (primo[k] !== mv(l[1:0]) || secondo[k] !== mv(l[3:2]) || inizia[k] !== 1'b0 || busy[k] !== 1'b1) begin
        bad++;
        $display("FAIL play_moves k=%0d got primo=%b secondo=%b inizia=%b busy=%b expected %b %b 0 1",
                 k, primo[k], secondo[k], inizia[k], busy[k], mv(l[1:0]), mv(l[3:2]));
      end
      if (mq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL match_overrun k=%0d got no match end after queued rounds expected an end", k);
        m = 2'b00;
        p = 2'b11;
      end else begin
        m = mq.pop_front();
        p = pq.pop_front();
      end
      manche = m;
      partita = p;
      tick;
      l = lf_next(l);
      case (m)
        2'b01: begin w1 = sat(w1); rn = sat(rn); end
        2'b10: begin w2 = sat(w2); rn = sat(rn); end
        2'b11: rn = sat(rn);
        default: ;
      endcase
      manche = 2'b00;
      partita = 2'b00;
      total++;
      if (primo[k] !== 2'b00 || secondo[k] !== 2'b00 || busy[k] !== 1'b1 || done[k] !== 1'b0 ||
          wins1[k] !== w1[3:0] || wins2[k] !== w2[3:0] || rounds[k] !== rn[3:0]) begin
        bad++;
        $display("FAIL check_tally k=%0d got primo=%b secondo=%b busy=%b done=%b w1=%0d w2=%0d rounds=%0d expected 00 00 1 0 %0d %0d %0d",
                 k, primo[k], secondo[k], busy[k], done[k], wins1[k], wins2[k], rounds[k], w1, w2, rn);
      end
      if (p != 2'b00) begin
        exp_res = p; exp_ab = 0; fin = 1;
      end else if (rn == maxr) begin
        exp_res = 2'b00; exp_ab = 1; fin = 1;
      end
    end
    tick;
    total++;
    if (done[k] !== 1'b1 || busy[k] !== 1'b0 || result[k] !== exp_res || abort[k] !== exp_ab ||
        wins1[k] !== w1[3:0] || wins2[k] !== w2[3:0] || rounds[k] !== rn[3:0]) begin
      bad++;
      $display("FAIL finish k=%0d got done=%b busy=%b result=%b abort=%b w1=%0d w2=%0d rounds=%0d expected 1 0 %b %b %0d %0d %0d",
               k, done[k], busy[k], result[k], abort[k], wins1[k], wins2[k], rounds[k], exp_res, exp_ab, w1, w2, rn);
    end
    tick;
    total++;
    if (done[k] !== 1'b0 || busy[k] !== 1'b0 || inizia[k] !== 1'b0 || result[k] !== exp_res ||
        abort[k] !== exp_ab || rounds[k] !== rn[3:0] || wins1[k] !== w1[3:0]) begin
      bad++;
      $display("FAIL idle_hold k=%0d got done=%b busy=%b inizia=%b result=%b abort=%b rounds=%0d w1=%0d expected 0 0 0 %b %b %0d %0d",
               k, done[k], busy[k], inizia[k], result[k], abort[k], rounds[k], wins1[k], exp_res, exp_ab, rn, w1);
    end
    if (hold) begin
      tick;
      total++;
      if (inizia[k] !== 1'b1 || busy[k] !== 1'b1 || rounds[k] !== 4'd0 || wins1[k] !== 4'd0 ||
          wins2[k] !== 4'd0 || abort[k] !== 1'b0 || result[k] !== 2'b00) begin
        bad++;
        $display("FAIL b2b_restart k=%0d got inizia=%b busy=%b rounds=%0d w1=%0d w2=%0d abort=%b result=%b expected 1 1 0 0 0 0 00",
                 k, inizia[k], busy[k], rounds[k], wins1[k], wins2[k], abort[k], result[k]);
      end
    end
    mq.delete();
    pq.delete();
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (primo[k] !== 2'b00 || secondo[k] !== 2'b00 || inizia[k] !== 1'b0 || busy[k] !== 1'b0 ||
          done[k] !== 1'b0 || result[k] !== 2'b00 || abort[k] !== 1'b0 || wins1[k] !== 4'd0 ||
          wins2[k] !== 4'd0 || rounds[k] !== 4'd0) begin
        bad++;
        $display("FAIL %s k=%0d got p=%b s=%b iz=%b busy=%b done=%b res=%b ab=%b w1=%0d w2=%0d r=%0d expected all zero",
                 name, k, primo[k], secondo[k], inizia[k], busy[k], done[k], result[k], abort[k], wins1[k], wins2[k], rounds[k]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_v = 3'b000; seed = 8'h00; manche = 2'b00; partita = 2'b00;
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_match;
    mq = '{2'b01, 2'b10, 2'b01};
    pq = '{2'b00, 2'b00, 2'b01};
    run_match(0, 15, 8'h00, 0);
  endtask

  task automatic test_invalid_rounds;
    mq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    pq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    run_match(0, 15, 8'h3C, 0);
  endtask

  task automatic test_abort;
    mq = '{2'b11, 2'b11, 2'b11};
    pq = '{2'b00, 2'b00, 2'b00};
    run_match(1, 2, 8'h00, 0);
  endtask

  task automatic test_reset_mid;
    seed = 8'h5D;
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    tick;
    manche = 2'b01;
    tick;
    manche = 2'b00;
    tick;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    #13 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || inizia[0] !== 1'b0 || rounds[0] !== 4'd0 || wins1[0] !== 4'd0) begin
        bad++;
        $display("FAIL reset_mid_idle cyc=%0d got done=%b busy=%b inizia=%b rounds=%0d w1=%0d expected 0 0 0 0 0",
                 i, done[0], busy[0], inizia[0], rounds[0], wins1[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    mq = '{2'b01, 2'b11};
    pq = '{2'b00, 2'b10};
    run_match(0, 15, 8'h81, 1);
    start_v[0] = 1'b0;
    tick;
    manche = 2'b11;
    partita = 2'b11;
    tick;
    manche = 2'b00;
    partita = 2'b00;
    tick;
    total++;
    if (done[0] !== 1'b1 || result[0] !== 2'b11 || rounds[0] !== 4'd1 || abort[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got done=%b result=%b rounds=%0d abort=%b expected 1 11 1 0",
               done[0], result[0], rounds[0], abort[0]);
    end
    tick;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) begin
      mq.push_back(2'b01);
      pq.push_back((i == 15) ? 2'b01 : 2'b00);
    end
    run_match(2, 20, 8'h17, 0);
  endtask

  task automatic test_random;
    logic [7:0] sd;
    int k, maxr;
    for (int t = 0; t < 8; t++) begin
      k = (t % 4 == 3) ? 1 : 0;
      maxr = (k == 1) ? 2 : 15;
      sd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < 64; i++) begin
        mq.push_back(2'($urandom_range(0, 3)));
        pq.push_back(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      run_match(k, maxr, sd, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_first_match;
    test_invalid_rounds;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_saturation;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
